// File: rtl/ewm_share_arb.sv
// ewm_share_arb
//   Round-robin arbiter and response router that lets NUM_REQ requesters
//   share one single-stage, 4-lane element-wise-multiply engine.
//   Each issued tile pushes its requester index into an in-order tag FIFO.
//   Each engine result is steered back to the requester at the FIFO head.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester issue handshake
//   req_a/req_b       packed operand tiles, requester r lane i at
//                     [(r*TILE_SIZE+i)*IN_W +: IN_W]
//   resp_valid/ready  per-requester result handshake
//   resp_y            shared result bus (valid for the asserted resp_valid bit)
//   ewm_*             engine input/output handshakes and data
//   inflight          tag FIFO occupancy
//   tag_err           sticky: engine produced a result with no tag outstanding
//
// Optional feature (macro EWM_SHARE_BURST_EN)
//   Adds req_last. An issue handshake without req_last locks the grant on
//   that requester until it issues a beat with req_last set.

module ewm_share_arb #(
    parameter int NUM_REQ   = 2,
    parameter int TILE_SIZE = 4,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int TAG_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
`ifdef EWM_SHARE_BURST_EN
    input  logic [NUM_REQ-1:0]                req_last,
`endif
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*TILE_SIZE*IN_W-1:0] req_a,
    input  logic [NUM_REQ*TILE_SIZE*IN_W-1:0] req_b,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [TILE_SIZE*OUT_W-1:0]        resp_y,
    output logic                              ewm_in_valid,
    input  logic                              ewm_in_ready,
    output logic [TILE_SIZE*IN_W-1:0]         ewm_a_vec,
    output logic [TILE_SIZE*IN_W-1:0]         ewm_b_vec,
    input  logic                              ewm_out_valid,
    output logic                              ewm_out_ready,
    input  logic [TILE_SIZE*OUT_W-1:0]        ewm_y_vec,
    output logic [$clog2(TAG_DEPTH+1)-1:0]    inflight,
    output logic                              tag_err
);

    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W     = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W     = $clog2(TAG_DEPTH + 1);
    localparam int TILE_BITS = TILE_SIZE * IN_W;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tag_err_q, tag_err_d;
    logic [IDX_W-1:0] tag_q [TAG_DEPTH];

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             can_issue;
    logic             push;
    logic             pop;
    logic             has_tag;
    logic [IDX_W-1:0] head;

`ifdef EWM_SHARE_BURST_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`endif

    // Only the registered count gates issue, so resp_ready never reaches req_ready combinationally.
    assign can_issue = (cnt_q < CNT_W'(TAG_DEPTH));
    assign has_tag   = (cnt_q != '0);
    assign head      = tag_q[rd_ptr_q];

    // Round-robin search from rr_ptr+1 with wrap. The loop runs from the
    // farthest candidate to the nearest, so the nearest valid one wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
`ifdef EWM_SHARE_BURST_EN
        // A burst in progress pins the grant, even while its owner idles.
        if (lock_q) begin
            grant_idx = lock_idx_q;
            grant_vld = req_valid[lock_idx_q];
        end
`endif
    end

    assign ewm_in_valid = can_issue & grant_vld;
    assign ewm_a_vec    = grant_vld ? req_a[int'(grant_idx)*TILE_BITS +: TILE_BITS] : '0;
    assign ewm_b_vec    = grant_vld ? req_b[int'(grant_idx)*TILE_BITS +: TILE_BITS] : '0;
    assign push         = ewm_in_valid & ewm_in_ready;

    always_comb begin
        req_ready = '0;
        if (grant_vld && can_issue && ewm_in_ready) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Response routing. An orphan result (no tag) is drained so the engine
    // cannot wedge, and it is flagged through tag_err.
    always_comb begin
        resp_valid = '0;
        if (has_tag && ewm_out_valid) begin
            resp_valid[head] = 1'b1;
        end
    end

    assign ewm_out_ready = has_tag ? resp_ready[head] : ewm_out_valid;
    assign resp_y        = ewm_y_vec;
    assign pop           = has_tag & ewm_out_valid & resp_ready[head];

    always_comb begin
        rr_ptr_d  = push ? grant_idx : rr_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        tag_err_d = tag_err_q | (ewm_out_valid & ~has_tag);
        cnt_d     = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

`ifdef EWM_SHARE_BURST_EN
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (push) begin
            lock_d     = ~req_last[grant_idx];
            lock_idx_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tag_err_q <= tag_err_d;
        end
    end

    // Tag storage holds data only; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign inflight = cnt_q;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_ewm_share_arb.sv
module tb_ewm_share_arb;

    localparam int NR = 2;
    localparam int TS = 4;
    localparam int W  = 16;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*TS*W-1:0] req_a;
    logic [NR*TS*W-1:0] req_b;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [TS*W-1:0]   resp_y;
    logic              ewm_in_valid;
    logic              ewm_in_ready;
    logic [TS*W-1:0]   ewm_a_vec;
    logic [TS*W-1:0]   ewm_b_vec;
    logic              ewm_out_valid;
    logic              ewm_out_ready;
    logic [TS*W-1:0]   ewm_y_vec;
    logic [1:0]        inflight;
    logic              tag_err;
`ifdef EWM_SHARE_BURST_EN
    logic [NR-1:0]     req_last;
`endif

    int n_vec = 0;
    int n_bad = 0;

    ewm_share_arb #(
        .NUM_REQ(NR), .TILE_SIZE(TS), .IN_W(W), .OUT_W(W), .TAG_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid),
`ifdef EWM_SHARE_BURST_EN
        .req_last(req_last),
`endif
        .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .ewm_in_valid(ewm_in_valid), .ewm_in_ready(ewm_in_ready),
        .ewm_a_vec(ewm_a_vec), .ewm_b_vec(ewm_b_vec),
        .ewm_out_valid(ewm_out_valid), .ewm_out_ready(ewm_out_ready),
        .ewm_y_vec(ewm_y_vec), .inflight(inflight), .tag_err(tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-stage engine: unsigned Q0.16 A times signed Q0.16 B.
    logic          e_vld;
    logic [TS*W-1:0] e_y;
    logic          force_ov;

    function automatic logic [TS*W-1:0] mul_tile(input logic [TS*W-1:0] a, input logic [TS*W-1:0] b);
        logic [TS*W-1:0] y;
        logic signed [35:0] p;
        y = '0;
        for (int i = 0; i < TS; i++) begin
            p = $signed({2'b00, a[i*W +: W]}) * $signed({{2{b[i*W+W-1]}}, b[i*W +: W]});
            y[i*W +: W] = p[31:16];
        end
        return y;
    endfunction

    assign ewm_out_valid = force_ov | e_vld;
    assign ewm_y_vec     = force_ov ? {TS{16'h5A5A}} : e_y;
    assign ewm_in_ready  = ewm_out_ready | ~e_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld <= 1'b0;
            e_y   <= '0;
        end else if (ewm_in_ready) begin
            e_vld <= ewm_in_valid;
            e_y   <= mul_tile(ewm_a_vec, ewm_b_vec);
        end
    end

    typedef struct {
        int          rid;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [TS*W-1:0] rep(input logic [15:0] v);
        return {TS{v}};
    endfunction

    function automatic logic [NR-1:0] oh(input int r);
        logic [NR-1:0] o;
        o = '0;
        o[r] = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input int r, input logic [15:0] a, input logic [15:0] b);
        req_a[r*TS*W +: TS*W] = rep(a);
        req_b[r*TS*W +: TS*W] = rep(b);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        force_ov   = 1'b0;
`ifdef EWM_SHARE_BURST_EN
        req_last   = '0;
`endif
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{0, 16'h8000, 16'h0100, 16'h0080};
        vecs[1] = '{1, 16'h8000, 16'h0100, 16'h0080};
        vecs[2] = '{0, 16'hFFFF, 16'h7FFF, 16'h7FFE};
        vecs[3] = '{1, 16'h8000, 16'hFF00, 16'hFF80};
        vecs[4] = '{0, 16'h4000, 16'h8000, 16'hE000};
        vecs[5] = '{1, 16'h0000, 16'h1234, 16'h0000};

        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        force_ov   = 1'b0;
`ifdef EWM_SHARE_BURST_EN
        req_last   = '0;
`endif
        step();
        step();
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_tag_err", 64'(tag_err), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_ewm_in_valid", 64'(ewm_in_valid), 64'd0);
        check("rst_ewm_out_ready", 64'(ewm_out_ready), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // Single-request vectors; the idle requester carries distractor data.
        for (int i = 0; i < 6; i++) begin
            req_a = {NR{rep(16'h1111)}};
            req_b = {NR{rep(16'h2222)}};
            set_tile(vecs[i].rid, vecs[i].a, vecs[i].b);
            req_valid  = oh(vecs[i].rid);
            resp_ready = '1;
            #1;
            check("vec_req_ready", 64'(req_ready), 64'(oh(vecs[i].rid)));
            check("vec_ewm_a", 64'(ewm_a_vec), 64'(rep(vecs[i].a)));
            step();
            req_valid = '0;
            #1;
            check("vec_resp_valid", 64'(resp_valid), 64'(oh(vecs[i].rid)));
            check("vec_resp_y", 64'(resp_y), 64'(rep(vecs[i].y)));
            check("vec_inflight_1", 64'(inflight), 64'd1);
            step();
            check("vec_inflight_0", 64'(inflight), 64'd0);
            check("vec_resp_idle", 64'(resp_valid), 64'd0);
        end

        // Continuous contention: grants alternate, results follow one cycle later.
        do_reset();
        set_tile(0, 16'h8000, 16'h0100);
        set_tile(1, 16'h8000, 16'h0200);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        begin
            int g;
            g = 0;
            for (int c = 0; c < 8; c++) begin
                #1;
                check("alt_grant", 64'(req_ready), 64'(oh(g)));
                if (c > 0) begin
                    check("alt_resp_valid", 64'(resp_valid), 64'(oh(1 - g)));
                    check("alt_resp_y", 64'(resp_y), 64'(rep((g == 1) ? 16'h0080 : 16'h0100)));
                end
                step();
                g = 1 - g;
            end
        end
        req_valid = '0;
        #1;
        check("alt_last_valid", 64'(resp_valid), 64'(oh(1)));
        check("alt_last_y", 64'(resp_y), 64'(rep(16'h0100)));
        step();
        check("alt_inflight", 64'(inflight), 64'd0);

        // Head requester stalls: nobody else may issue until it drains.
        do_reset();
        set_tile(1, 16'h8000, 16'h0100);
        set_tile(0, 16'h8000, 16'h0200);
        req_valid  = 2'b10;
        resp_ready = 2'b01;
        #1;
        check("bp_issue1", 64'(req_ready), 64'(2'b10));
        step();
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_resp_valid", 64'(resp_valid), 64'(2'b10));
            step();
        end
        resp_ready = 2'b11;
        #1;
        check("bp_rel_resp", 64'(resp_valid), 64'(2'b10));
        check("bp_rel_y", 64'(resp_y), 64'(rep(16'h0080)));
        check("bp_rel_grant0", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0;
        #1;
        check("bp_r0_resp", 64'(resp_valid), 64'(2'b01));
        check("bp_r0_y", 64'(resp_y), 64'(rep(16'h0100)));
        step();
        check("bp_inflight", 64'(inflight), 64'd0);

        // Reset with a result pending on the engine output.
        do_reset();
        set_tile(0, 16'h8000, 16'h0100);
        req_valid  = 2'b01;
        resp_ready = 2'b00;
        step();
        req_valid = '0;
        #1;
        check("mr_inflight_1", 64'(inflight), 64'd1);
        check("mr_resp_valid", 64'(resp_valid), 64'(2'b01));
        rst_n = 1'b0;
        #1;
        check("mr_resp_valid_0", 64'(resp_valid), 64'd0);
        check("mr_out_ready_0", 64'(ewm_out_ready), 64'd0);
        check("mr_inflight_0", 64'(inflight), 64'd0);
        check("mr_in_valid_0", 64'(ewm_in_valid), 64'd0);
        step();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        check("mr_first_grant", 64'(req_ready), 64'(2'b01));
        step();
        req_valid  = '0;
        resp_ready = 2'b11;
        step();
        check("mr_drained", 64'(inflight), 64'd0);

        // Orphan engine result with an empty tag FIFO.
        force_ov = 1'b1;
        #1;
        check("te_resp_valid", 64'(resp_valid), 64'd0);
        check("te_out_ready", 64'(ewm_out_ready), 64'd1);
        check("te_before", 64'(tag_err), 64'd0);
        step();
        force_ov = 1'b0;
        #1;
        check("te_set", 64'(tag_err), 64'd1);
        check("te_resp_idle", 64'(resp_valid), 64'd0);
        step();
        step();
        step();
        check("te_sticky", 64'(tag_err), 64'd1);
        check("te_inflight", 64'(inflight), 64'd0);

`ifdef EWM_SHARE_BURST_EN
        // Burst from requester 0 holds the grant until its last beat.
        do_reset();
        set_tile(0, 16'h8000, 16'h0100);
        set_tile(1, 16'h8000, 16'h0200);
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        req_last   = 2'b00;
        #1;
        check("bu_beat0", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = 2'b10;
        #1;
        check("bu_gap_lock", 64'(req_ready), 64'd0);
        check("bu_gap_in_valid", 64'(ewm_in_valid), 64'd0);
        step();
        req_valid = 2'b11;
        #1;
        check("bu_beat1", 64'(req_ready), 64'(2'b01));
        step();
        req_last = 2'b01;
        #1;
        check("bu_beat2", 64'(req_ready), 64'(2'b01));
        step();
        req_last = 2'b00;
        #1;
        check("bu_after", 64'(req_ready), 64'(2'b10));
        step();
        req_valid = '0;
        step();
        step();
        check("bu_inflight", 64'(inflight), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ewm_share_arb.md
Name: ewm_share_arb

Overview:
- Round-robin arbiter and response router that shares one 4-lane element-wise-multiply engine (1-stage, `in_ready = out_ready || !out_valid`) between NUM_REQ requesters.
- Typical requesters in the SSM state-update path: the lambda*h stream and the B*u stream.
- Grants one request per cycle, forwards its operand tiles to the engine, and records the requester index in an in-order tag FIFO.
- Steers each engine result back to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TILE_SIZE, 4, lanes per tile.
- IN_W, 16, operand lane width.
- OUT_W, 16, result lane width.
- TAG_DEPTH, 2, in-flight tag FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a  in  NUM_REQ*TILE_SIZE*IN_W  operand A tiles; requester r occupies slice r, lane i at bits [(r*TILE_SIZE+i)*IN_W +: IN_W].
- req_b  in  NUM_REQ*TILE_SIZE*IN_W  operand B tiles, same packing.
- resp_valid  out  NUM_REQ  per-requester result valid.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_y  out  TILE_SIZE*OUT_W  result tile, shared bus, valid only for the asserted resp_valid bit.
- ewm_in_valid  out  1  engine input valid.
- ewm_in_ready  in  1  engine input ready.
- ewm_a_vec  out  TILE_SIZE*IN_W  engine operand A.
- ewm_b_vec  out  TILE_SIZE*IN_W  engine operand B.
- ewm_out_valid  in  1  engine result valid.
- ewm_out_ready  out  1  engine result accept.
- ewm_y_vec  in  TILE_SIZE*OUT_W  engine result.
- inflight  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy.
- tag_err  out  1  sticky: engine produced a result while the tag FIFO was empty.

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - Tag FIFO empty, inflight=0, tag_err=0.
  - All outputs derived from this state are 0: req_ready, resp_valid, ewm_in_valid, ewm_out_ready.
  - A reset mid-operation drops all in-flight tags. The engine is reset by the same rst_n.
- can_issue = (inflight < TAG_DEPTH), taken from registered count only; no combinational path from resp_ready to req_ready.
- Grant (combinational): the first requester with req_valid=1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
- ewm_in_valid = can_issue & |req_valid.
- ewm_a_vec / ewm_b_vec = granted requester's slice; all zeros when there is no grant.
- req_ready[g] = can_issue & ewm_in_ready for the granted g; all other bits are 0.
- Issue handshake (ewm_in_valid & ewm_in_ready): push g into the tag FIFO; rr_ptr <= g.
  - With no handshake, rr_ptr holds.
- Response routing:
  - head = FIFO head tag.
  - resp_valid[head] = ewm_out_valid & (inflight != 0); all other bits are 0.
  - resp_y = ewm_y_vec, passed through.
  - ewm_out_ready = resp_ready[head] when inflight != 0.
  - A response handshake pops the head.
- Simultaneous push and pop: inflight unchanged; pointers advance. Push when full cannot occur (gated). Pop when empty cannot occur.
- ewm_out_valid with inflight=0:
  - tag_err <= 1 and stays set until reset.
  - ewm_out_ready = 1 to drain the result; resp_valid all 0.
- Latency: request handshake at cycle N → resp_valid at N+1, given the engine's single register stage.
- Throughput: 1 tile/cycle when the head requester keeps resp_ready=1.
- Backpressure: a stalled head requester stalls the engine. The engine then drops ewm_in_ready, so no requester is granted. Results stay in issue order; no reordering.

Optional Feature:
- Macro EWM_SHARE_BURST_EN.
- When defined:
  - Adds input req_last (NUM_REQ bits).
  - After an issue handshake from g with req_last[g]=0, a lock holds the grant on g: other requesters get req_ready=0 even if g drops req_valid.
  - The lock releases on an issue handshake from g with req_last[g]=1. Reset clears the lock.
- When not defined: no req_last port; arbitration is pure per-beat round-robin.

Test Plan:
- Reset, then one request from requester 0 (all lanes a=0x8000, b=0x0100, unsigned A/signed B Q0.16) → next cycle resp_valid=2'b01, every lane of resp_y=0x0080; inflight returns to 0.
- Both requesters valid continuously, resp_ready=2'b11 → grants alternate 0,1,0,1 over 8 cycles. Each response arrives 1 cycle after issue on the matching resp_valid bit; 8 results in 9 cycles.
- Requester 1 issues, then resp_ready[1]=0 for 5 cycles while requester 0 is valid → req_ready[0]=0 throughout. Release → requester 1 result delivered first, then requester 0 issues.
- Reset asserted while inflight=1 and ewm_out_valid=1 → all outputs 0 immediately. After release, first grant goes to requester 0.
- Force ewm_out_valid=1 with the FIFO empty → tag_err=1 next cycle and stays 1; resp_valid stays 0.
- With EWM_SHARE_BURST_EN: requester 0 sends 3 beats with req_last=0,0,1 while requester 1 is valid → grant sequence 0,0,0,1.
